// File: rtl/inst_fetch.sv
// Program RAM for the 6-bit accumulator core: loaded over a valid/ready port, then streamed in order to the decoder.
// Optional INST_FETCH_LOOP_EN adds a loop input that restarts the program without a bubble at end of program.
module inst_fetch #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [5:0]    ld_data,
  input  logic          ld_last,
  input  logic          start,
  input  logic          stall,
`ifdef INST_FETCH_LOOP_EN
  input  logic          loop,
`endif
  output logic [5:0]    inst,
  output logic          inst_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  localparam logic [5:0] NOP = 6'b111100;

  typedef enum logic [1:0] {IDLE, LOADED, RUN} state_e;

  state_e        state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] pc_q;
  logic [AW:0]   len_q;
  logic [5:0]    inst_q;
  logic          inst_valid_q;
  logic          busy_q;
  logic          done_q;
  logic [5:0]    mem [2**AW];

  logic          ld_acc;
  logic          consume;
  logic          last_word;
  logic          loop_en;
  logic [AW-1:0] pc_d;

`ifdef INST_FETCH_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign ld_ready  = (state_q == IDLE);
  assign ld_acc    = ld_valid && ld_ready;
  assign consume   = inst_valid_q && !stall;
  assign last_word = ({1'b0, pc_q} == (len_q - 1'b1));
  assign pc_d      = pc_q + 1'b1;

  // RAM has no reset; contents survive reset but len=0 makes them unreachable.
  always_ff @(posedge clk) begin
    if (rst_n && ld_acc) begin
      mem[wr_ptr_q] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      len_q        <= '0;
      pc_q         <= '0;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ld_acc) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            // a full RAM closes the program even without ld_last
            if (ld_last || (&wr_ptr_q)) begin
              len_q    <= {1'b0, wr_ptr_q} + 1'b1;
              wr_ptr_q <= '0;
              state_q  <= LOADED;
            end
          end
        end
        LOADED: begin
          if (start) begin
            state_q      <= RUN;
            pc_q         <= '0;
            inst_q       <= mem[0];
            inst_valid_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        RUN: begin
          if (consume) begin
            if (!last_word) begin
              pc_q   <= pc_d;
              inst_q <= mem[pc_d];
            end else if (loop_en) begin
              pc_q   <= '0;
              inst_q <= mem[0];
              done_q <= 1'b1;
            end else begin
              pc_q         <= '0;
              inst_q       <= NOP;
              inst_valid_q <= 1'b0;
              busy_q       <= 1'b0;
              done_q       <= 1'b1;
              state_q      <= LOADED;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: load, run, stall, full-RAM load, reset abort, start filtering, optional loop.
module tb_inst_fetch;

  localparam int AW = 4;
  localparam logic [5:0] NOP = 6'b111100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_valid;
  logic          ld_ready;
  logic [5:0]    ld_data;
  logic          ld_last;
  logic          start;
  logic          stall;
`ifdef INST_FETCH_LOOP_EN
  logic          loop;
`endif
  logic [5:0]    inst;
  logic          inst_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  int n_chk  = 0;
  int n_fail = 0;

  inst_fetch #(.AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .start     (start),
    .stall     (stall),
`ifdef INST_FETCH_LOOP_EN
    .loop      (loop),
`endif
    .inst      (inst),
    .inst_valid(inst_valid),
    .pc        (pc),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the full output bundle in one go.
  task automatic chk_out(input string tag, input logic [5:0] e_inst, input logic e_vld,
                         input logic [AW-1:0] e_pc, input logic e_busy, input logic e_done);
    chk({tag, ".inst"}, {10'd0, inst}, {10'd0, e_inst});
    chk({tag, ".vld"},  {15'd0, inst_valid}, {15'd0, e_vld});
    chk({tag, ".pc"},   {12'd0, pc}, {12'd0, e_pc});
    chk({tag, ".busy"}, {15'd0, busy}, {15'd0, e_busy});
    chk({tag, ".done"}, {15'd0, done}, {15'd0, e_done});
  endtask

  task automatic load(input logic [5:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  initial begin
    logic [5:0] w;
    rst_n = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; start = 1'b0; stall = 1'b0;
`ifdef INST_FETCH_LOOP_EN
    loop = 1'b0;
`endif
    tick(); tick();
    chk_out("rst", NOP, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("rst.ld_ready", {15'd0, ld_ready}, 16'd1);

    // start while IDLE is ignored
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk_out("idle_start", NOP, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("idle_start.ld_ready", {15'd0, ld_ready}, 16'd1);

    // 3-word program
    load(6'h1D, 1'b0);
    load(6'h02, 1'b0);
    chk("load3.ld_ready_mid", {15'd0, ld_ready}, 16'd1);
    load(6'h3C, 1'b1);
    chk("load3.ld_ready", {15'd0, ld_ready}, 16'd0);
    chk_out("loaded", NOP, 1'b0, 4'd0, 1'b0, 1'b0);

    start = 1'b1; tick(); start = 1'b0;
    chk_out("run.w0", 6'h1D, 1'b1, 4'd0, 1'b1, 1'b0);
    tick(); chk_out("run.w1", 6'h02, 1'b1, 4'd1, 1'b1, 1'b0);
    tick(); chk_out("run.w2", 6'h3C, 1'b1, 4'd2, 1'b1, 1'b0);
    tick(); chk_out("run.end", NOP, 1'b0, 4'd0, 1'b0, 1'b1);
    tick(); chk_out("run.after", NOP, 1'b0, 4'd0, 1'b0, 1'b0);

    // re-run with stall on word 1 and start held high through RUN and the done edge
    start = 1'b1; tick();
    chk_out("st.w0", 6'h1D, 1'b1, 4'd0, 1'b1, 1'b0);
    tick(); chk_out("st.w1a", 6'h02, 1'b1, 4'd1, 1'b1, 1'b0);
    stall = 1'b1;
    tick(); chk_out("st.w1b", 6'h02, 1'b1, 4'd1, 1'b1, 1'b0);
    tick(); chk_out("st.w1c", 6'h02, 1'b1, 4'd1, 1'b1, 1'b0);
    stall = 1'b0;
    tick(); chk_out("st.w2", 6'h3C, 1'b1, 4'd2, 1'b1, 1'b0);
    tick(); chk_out("st.end", NOP, 1'b0, 4'd0, 1'b0, 1'b1);
    start = 1'b0;
    tick(); chk_out("st.after", NOP, 1'b0, 4'd0, 1'b0, 1'b0);

    // reset while pc=1 aborts the run; start afterwards in IDLE is ignored
    start = 1'b1; tick(); start = 1'b0;
    tick(); chk_out("ra.w1", 6'h02, 1'b1, 4'd1, 1'b1, 1'b0);
    rst_n = 1'b0; start = 1'b1;
    tick();
    chk_out("ra.rst", NOP, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("ra.ld_ready", {15'd0, ld_ready}, 16'd1);
    rst_n = 1'b1;
    tick();
    start = 1'b0;
    chk_out("ra.idle", NOP, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("ra.ld_ready2", {15'd0, ld_ready}, 16'd1);

    // full RAM without ld_last, then a 17th word that must be dropped
    for (int i = 0; i < 16; i++) begin
      w = 6'(i * 5 + 3);
      load(w, 1'b0);
    end
    chk("full.ld_ready", {15'd0, ld_ready}, 16'd0);
    load(6'h11, 1'b0);
    chk("full.ld_ready17", {15'd0, ld_ready}, 16'd0);
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      w = 6'(i * 5 + 3);
      chk_out($sformatf("full.w%0d", i), w, 1'b1, 4'(i), 1'b1, 1'b0);
      tick();
    end
    chk_out("full.end", NOP, 1'b0, 4'd0, 1'b0, 1'b1);

    // single-word program
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    load(6'h07, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    chk_out("len1.w0", 6'h07, 1'b1, 4'd0, 1'b1, 1'b0);
    tick(); chk_out("len1.end", NOP, 1'b0, 4'd0, 1'b0, 1'b1);

`ifdef INST_FETCH_LOOP_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    load(6'h05, 1'b0);
    load(6'h0A, 1'b1);
    loop = 1'b1; start = 1'b1; tick(); start = 1'b0;
    chk_out("lp.w0", 6'h05, 1'b1, 4'd0, 1'b1, 1'b0);
    tick(); chk_out("lp.w1", 6'h0A, 1'b1, 4'd1, 1'b1, 1'b0);
    tick(); chk_out("lp.wrap", 6'h05, 1'b1, 4'd0, 1'b1, 1'b1);
    tick(); chk_out("lp.w1b", 6'h0A, 1'b1, 4'd1, 1'b1, 1'b0);
    loop = 1'b0;
    tick(); chk_out("lp.end", NOP, 1'b0, 4'd0, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
